axi_wr_ctrl_fsm: RTL and testbench

- Parametrised AXI4 write-channel control FSM; next generation of the single-stream write controller.
- Accepts one AW burst at a time and steers its W beats into one of NUM_CH datapath input FIFOs (varint / raw-data lanes), selected by address bits.
- Generates the B response with error coding, and issues register load/clear strobes to the datapath.

---
 rtl/axi_wr_ctrl_fsm.sv | 221 ++++++++++++++++++++++
 tb/tb_axi_wr_ctrl_fsm.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_ctrl_fsm.sv
// AXI4 write-channel control FSM: routes W beats of one AW burst into NUM_CH FIFOs and issues B.
// Optional burst/stall performance counters are enabled with `define AXI_WR_CTRL_PERF_EN.
module axi_wr_ctrl_fsm #(
  parameter int NUM_CH  = 2,
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32,
  parameter int SEL_LSB = 12
) (
  input  logic              clock_clk,
  input  logic              reset_reset,
  input  logic              axs_s0_awvalid,
  output logic              axs_s0_awready,
  input  logic [ID_W-1:0]   axs_s0_awid,
  input  logic [ADDR_W-1:0] axs_s0_awaddr,
  input  logic [7:0]        axs_s0_awlen,
  input  logic [1:0]        axs_s0_awburst,
  input  logic              axs_s0_wvalid,
  output logic              axs_s0_wready,
  input  logic              axs_s0_wlast,
  output logic              axs_s0_bvalid,
  input  logic              axs_s0_bready,
  output logic [ID_W-1:0]   axs_s0_bid,
  output logic [1:0]        axs_s0_bresp,
  input  logic [NUM_CH-1:0] fifo_full,
  output logic [NUM_CH-1:0] fifo_push,
  output logic [NUM_CH-1:0] fifo_clr,
  input  logic              sw_clr,
  output logic              aw_reg_ld,
  output logic              w_reg_ld,
  output logic [7:0]        beat_idx
`ifdef AXI_WR_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_bursts,
  output logic [31:0]       perf_stalls
`endif
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_CLR,
    ST_IDLE,
    ST_DATA,
    ST_RESP
  } state_e;

  state_e            state_q,    state_d;
  logic [ID_W-1:0]   id_q,       id_d;
  logic [7:0]        len_q,      len_d;
  logic [CH_W-1:0]   ch_q,       ch_d;
  logic [1:0]        err_q,      err_d;
  logic [7:0]        beat_q,     beat_d;
  logic              bvalid_q,   bvalid_d;
  logic [ID_W-1:0]   bid_q,      bid_d;
  logic [1:0]        bresp_q,    bresp_d;
  logic              clr_pend_q, clr_pend_d;

  logic [CH_W-1:0] aw_ch;
  logic [1:0]      aw_err;
  logic [1:0]      beat_err;
  logic            full_sel;
  logic            aw_hs;
  logic            w_hs;
  logic            b_hs;
  logic            last_beat;
  logic            unused_addr;

  assign aw_ch       = axs_s0_awaddr[SEL_LSB +: CH_W];
  assign unused_addr = ^axs_s0_awaddr;
  assign last_beat   = (beat_q == len_q);

  // Burst type 2'b10 (WRAP) and 2'b11 (reserved) both have bit 1 set.
  always_comb begin
    if (int'(aw_ch) >= NUM_CH)   aw_err = RESP_DECERR;
    else if (axs_s0_awburst[1])  aw_err = RESP_SLVERR;
    else                         aw_err = RESP_OKAY;
  end

  // An out-of-range channel matches no index and reads as not full.
  always_comb begin
    full_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) full_sel = fifo_full[i];
    end
  end

  assign axs_s0_awready = ~reset_reset & (state_q == ST_IDLE) & ~clr_pend_q;
  assign axs_s0_wready  = ~reset_reset & (state_q == ST_DATA) &
                          ((err_q != RESP_OKAY) | ~full_sel);
  assign axs_s0_bvalid  = ~reset_reset & bvalid_q;
  assign axs_s0_bid     = bid_q;
  assign axs_s0_bresp   = bresp_q;
  assign beat_idx       = beat_q;

  assign aw_hs = axs_s0_awvalid & axs_s0_awready;
  assign w_hs  = axs_s0_wvalid  & axs_s0_wready;
  assign b_hs  = axs_s0_bvalid  & axs_s0_bready;

  assign aw_reg_ld = aw_hs;
  assign w_reg_ld  = w_hs;
  assign fifo_clr  = {NUM_CH{~reset_reset & (state_q == ST_CLR)}};

  always_comb begin
    fifo_push = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      fifo_push[i] = w_hs & (err_q == RESP_OKAY) & (ch_q == CH_W'(i));
    end
  end

  // A wlast that disagrees with the length count only downgrades an OKAY burst.
  always_comb begin
    beat_err = err_q;
    if ((axs_s0_wlast != last_beat) && (err_q == RESP_OKAY)) beat_err = RESP_SLVERR;
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block leaves a latch.
    state_d    = state_q;
    id_d       = id_q;
    len_d      = len_q;
    ch_d       = ch_q;
    err_d      = err_q;
    beat_d     = beat_q;
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    clr_pend_d = clr_pend_q | sw_clr;

    unique case (state_q)
      ST_CLR: begin
        clr_pend_d = sw_clr;
        state_d    = ST_IDLE;
      end
      ST_IDLE: begin
        if (clr_pend_q) begin
          state_d = ST_CLR;
        end else if (aw_hs) begin
          id_d    = axs_s0_awid;
          len_d   = axs_s0_awlen;
          ch_d    = aw_ch;
          err_d   = aw_err;
          beat_d  = 8'd0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          err_d = beat_err;
          if (last_beat) begin
            bvalid_d = 1'b1;
            bid_d    = id_q;
            bresp_d  = beat_err;
            state_d  = ST_RESP;
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      ST_RESP: begin
        if (b_hs) begin
          bvalid_d = 1'b0;
          state_d  = clr_pend_q ? ST_CLR : ST_IDLE;
        end
      end
      default: state_d = ST_CLR;
    endcase
  end

  // NOTE: sequential state is only ever assigned with <= so all registers update together.
  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      state_q    <= ST_CLR;
      id_q       <= '0;
      len_q      <= '0;
      ch_q       <= '0;
      err_q      <= RESP_OKAY;
      beat_q     <= '0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      len_q      <= len_d;
      ch_q       <= ch_d;
      err_q      <= err_d;
      beat_q     <= beat_d;
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      clr_pend_q <= clr_pend_d;
    end
  end

`ifdef AXI_WR_CTRL_PERF_EN
  logic [31:0] perf_bursts_q;
  logic [31:0] perf_stalls_q;
  logic        stall;

  assign stall       = (state_q == ST_DATA) & axs_s0_wvalid & ~axs_s0_wready;
  assign perf_bursts = perf_bursts_q;
  assign perf_stalls = perf_stalls_q;

  // Saturating counters, restarted on every FIFO clear.
  always_ff @(posedge clock_clk) begin
    if (reset_reset || (state_q == ST_CLR)) begin
      perf_bursts_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (b_hs  && !(&perf_bursts_q)) perf_bursts_q <= perf_bursts_q + 32'd1;
      if (stall && !(&perf_stalls_q)) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_wr_ctrl_fsm.sv
// Scoreboard bench for axi_wr_ctrl_fsm: stimulus queues expected beats/B responses, a monitor checks them.
// Three channels are used so the 2-bit select field can address an out-of-range channel.
module tb_axi_wr_ctrl_fsm;
  localparam int N    = 3;
  localparam int ID_W = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          awvalid, awready;
  logic [3:0]    awid;
  logic [31:0]   awaddr;
  logic [7:0]    awlen;
  logic [1:0]    awburst;
  logic          wvalid, wready, wlast;
  logic          bvalid, bready;
  logic [3:0]    bid;
  logic [1:0]    bresp;
  logic [N-1:0]  fifo_full, fifo_push, fifo_clr;
  logic          sw_clr, aw_reg_ld, w_reg_ld;
  logic [7:0]    beat_idx;
`ifdef AXI_WR_CTRL_PERF_EN
  logic [31:0]   perf_bursts, perf_stalls;
`endif

  axi_wr_ctrl_fsm #(.NUM_CH(N), .ID_W(ID_W), .ADDR_W(32), .SEL_LSB(12)) dut (
    .clock_clk(clk), .reset_reset(rst),
    .axs_s0_awvalid(awvalid), .axs_s0_awready(awready), .axs_s0_awid(awid),
    .axs_s0_awaddr(awaddr), .axs_s0_awlen(awlen), .axs_s0_awburst(awburst),
    .axs_s0_wvalid(wvalid), .axs_s0_wready(wready), .axs_s0_wlast(wlast),
    .axs_s0_bvalid(bvalid), .axs_s0_bready(bready), .axs_s0_bid(bid), .axs_s0_bresp(bresp),
    .fifo_full(fifo_full), .fifo_push(fifo_push), .fifo_clr(fifo_clr),
    .sw_clr(sw_clr), .aw_reg_ld(aw_reg_ld), .w_reg_ld(w_reg_ld), .beat_idx(beat_idx)
`ifdef AXI_WR_CTRL_PERF_EN
    , .perf_bursts(perf_bursts), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [N-1:0] push; logic [7:0] idx; } beat_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

  beat_t exp_w[$];
  bexp_t exp_b[$];
  beat_t cur_w;
  bexp_t cur_b;
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, where all inputs and outputs are settled.
  always @(negedge clk) begin
    if (awvalid && awready) check("aw_reg_ld", aw_reg_ld, 1);
    if (wvalid && wready) begin
      if (exp_w.size() == 0) begin
        total++; bad++;
        $display("FAIL w_unexpected: push=%b idx=%0d expected no beat", fifo_push, beat_idx);
      end else begin
        cur_w = exp_w.pop_front();
        check("fifo_push", fifo_push, cur_w.push);
        check("beat_idx", beat_idx, cur_w.idx);
        check("w_reg_ld", w_reg_ld, 1);
      end
    end else if (fifo_push != '0 || w_reg_ld) begin
      total++; bad++;
      $display("FAIL stray_w_strobe: push=%b w_reg_ld=%b expected none", fifo_push, w_reg_ld);
    end
    if (!(awvalid && awready) && aw_reg_ld) begin
      total++; bad++;
      $display("FAIL stray_aw_reg_ld: got=1 expected=0");
    end
    if (bvalid && bready) begin
      if (exp_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected: bid=%0h bresp=%0h expected no response", bid, bresp);
      end else begin
        cur_b = exp_b.pop_front();
        check("bid", bid, cur_b.id);
        check("bresp", bresp, cur_b.resp);
      end
    end
  end

  // First npush beats carry push, the rest carry none.
  task automatic expect_burst(input logic [N-1:0] push, input int n, input int npush,
                              input logic [3:0] id, input logic [1:0] resp, input bit with_b);
    beat_t e;
    bexp_t b;
    for (int i = 0; i < n; i++) begin
      e.push = (i < npush) ? push : '0;
      e.idx  = 8'(i);
      exp_w.push_back(e);
    end
    if (with_b) begin
      b.id = id; b.resp = resp;
      exp_b.push_back(b);
    end
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst);
    bit ok = 0;
    awvalid = 1; awid = id; awaddr = addr; awlen = len; awburst = burst;
    for (int g = 0; g < 50; g++) begin
      @(negedge clk);
      if (awready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    check("aw_accept", ok, 1);
    @(posedge clk); #1;
    awvalid = 0;
  endtask

  // wlast is correct except on beat last_flip; beat stall_idx sees stall_mask full for 2 cycles.
  task automatic do_w(input int n, input int last_flip, input int stall_idx,
                      input logic [N-1:0] stall_mask, input int clr_idx, output int cycles);
    bit ok;
    cycles = 0;
    for (int b = 0; b < n; b++) begin
      wvalid = 1;
      wlast  = (b == n - 1) ^ (b == last_flip);
      sw_clr = (b == clr_idx);
      if (b == stall_idx) begin
        fifo_full = stall_mask;
        repeat (2) begin
          @(negedge clk);
          check("stall_wready", wready, 0);
          @(posedge clk);
          cycles++;
        end
        #1 fifo_full = '0;
      end
      ok = 0;
      for (int g = 0; g < 50; g++) begin
        @(negedge clk);
        if (wready) begin ok = 1; break; end
        @(posedge clk); #1;
        cycles++;
      end
      if (!ok) check("w_accept", ok, 1);
      @(posedge clk); #1;
      cycles++;
      sw_clr = 0;
    end
    wvalid = 0; wlast = 0;
  endtask

  int cyc;

  initial begin
    rst = 1; awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awburst = 2'b01;
    wvalid = 0; wlast = 0; bready = 1; fifo_full = '0; sw_clr = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_fifo_clr", fifo_clr, 0);
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_beat_idx", beat_idx, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("clr_cycle_fifo_clr", fifo_clr, 3'b111);
    check("clr_cycle_awready", awready, 0);
    @(negedge clk);
    check("idle_fifo_clr", fifo_clr, 0);
    check("idle_awready", awready, 1);

    // INCR burst to channel 1, back to back.
    @(posedge clk); #1;
    expect_burst(3'b010, 4, 4, 4'd5, 2'b00, 1);
    do_aw(4'd5, 32'h1000, 8'd3, 2'b01);
    do_w(4, -1, -1, '0, -1, cyc);
    check("b2b_cycles", cyc, 4);
    @(negedge clk);
    check("bvalid_latency", bvalid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("awready_after_b", awready, 1);

    // Same burst with channel 1 full for 2 cycles before beat 2.
    @(posedge clk); #1;
    expect_burst(3'b010, 4, 4, 4'd6, 2'b00, 1);
    do_aw(4'd6, 32'h1000, 8'd3, 2'b01);
    do_w(4, -1, 2, 3'b010, -1, cyc);
    check("stall_cycles", cyc, 6);
    @(negedge clk);
    @(posedge clk); #1;
`ifdef AXI_WR_CTRL_PERF_EN
    @(negedge clk);
    check("perf_stalls", perf_stalls, 2);
    check("perf_bursts", perf_bursts, 2);
    @(posedge clk); #1;
`endif

    // Out-of-range channel 3: drained, DECERR, B held while bready is low.
    bready = 0;
    expect_burst('0, 2, 0, 4'd3, 2'b11, 1);
    do_aw(4'd3, 32'h3000, 8'd1, 2'b01);
    do_w(2, -1, -1, '0, -1, cyc);
    repeat (3) begin
      @(negedge clk);
      check("hold_bvalid", bvalid, 1);
      check("hold_bid", bid, 4'd3);
      check("hold_bresp", bresp, 2'b11);
    end
    @(posedge clk); #1 bready = 1;
    repeat (2) @(posedge clk);
    #1;

    // WRAP and reserved burst types: drained, SLVERR.
    expect_burst('0, 4, 0, 4'd7, 2'b10, 1);
    do_aw(4'd7, 32'h1000, 8'd3, 2'b10);
    do_w(4, -1, -1, '0, -1, cyc);
    repeat (2) @(posedge clk);
    #1;
    expect_burst('0, 1, 0, 4'd13, 2'b10, 1);
    do_aw(4'd13, 32'h1000, 8'd0, 2'b11);
    do_w(1, -1, -1, '0, -1, cyc);
    repeat (2) @(posedge clk);
    #1;

    // Early wlast on beat 1: beats 0 and 1 pushed before the error is recorded.
    expect_burst(3'b010, 4, 2, 4'd8, 2'b10, 1);
    do_aw(4'd8, 32'h1000, 8'd3, 2'b01);
    do_w(4, 1, -1, '0, -1, cyc);
    repeat (2) @(posedge clk);
    #1;

    // awlen=0 without wlast, then a clean awlen=0 burst to channel 2.
    expect_burst(3'b001, 1, 1, 4'd9, 2'b10, 1);
    do_aw(4'd9, 32'h0000, 8'd0, 2'b01);
    do_w(1, 0, -1, '0, -1, cyc);
    repeat (2) @(posedge clk);
    #1;
    expect_burst(3'b100, 1, 1, 4'd10, 2'b00, 1);
    do_aw(4'd10, 32'h2000, 8'd0, 2'b01);
    do_w(1, -1, -1, '0, -1, cyc);
    repeat (2) @(posedge clk);
    #1;

    // sw_clr during beat 1: burst completes, then one CLR cycle.
    expect_burst(3'b100, 3, 3, 4'd11, 2'b00, 1);
    do_aw(4'd11, 32'h2000, 8'd2, 2'b01);
    do_w(3, -1, -1, '0, 1, cyc);
    @(negedge clk);
    check("swclr_bvalid", bvalid, 1);
    check("swclr_no_early_clr", fifo_clr, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("swclr_fifo_clr", fifo_clr, 3'b111);
    check("swclr_awready", awready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("swclr_done_fifo_clr", fifo_clr, 0);
    check("swclr_done_awready", awready, 1);
    @(posedge clk); #1;

    // awlen=255: beat_idx runs 0..255 and stops there.
    expect_burst(3'b001, 256, 256, 4'd12, 2'b00, 1);
    do_aw(4'd12, 32'h0000, 8'd255, 2'b01);
    do_w(256, -1, -1, '0, -1, cyc);
    check("len255_cycles", cyc, 256);
    @(negedge clk);
    check("len255_beat_idx", beat_idx, 8'd255);
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-burst: abandoned, no B, CLR follows.
    expect_burst(3'b010, 2, 2, 4'd14, 2'b00, 0);
    do_aw(4'd14, 32'h1000, 8'd3, 2'b01);
    do_w(2, -1, -1, '0, -1, cyc);
    rst = 1;
    @(negedge clk);
    check("midrst_wready", wready, 0);
    check("midrst_fifo_clr", fifo_clr, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("midrst_clr", fifo_clr, 3'b111);
    check("midrst_beat_idx", beat_idx, 0);
    check("midrst_bvalid", bvalid, 0);
    @(posedge clk); #1;

    expect_burst(3'b100, 2, 2, 4'd15, 2'b00, 1);
    do_aw(4'd15, 32'h2000, 8'd1, 2'b01);
    do_w(2, -1, -1, '0, -1, cyc);

    for (int g = 0; g < 20 && (exp_w.size() != 0 || exp_b.size() != 0); g++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("exp_w_left", exp_w.size(), 0);
    check("exp_b_left", exp_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
